// File: rtl/id_stage_pkg.sv
// Shared decode definitions for the instruction-decode stage: opcodes,
// ALU operation encodings and the control bundle handed to execute.
package id_stage_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       illegal;
    logic [1:0] alu_op;
  } ctrl_t;

  function automatic ctrl_t decode_op(input logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      OP_RTYPE: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
        c.alu_op    = ALU_FUNCT;
      end
      OP_LW: begin
        c.alu_src    = 1'b1;
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
        c.mem_read   = 1'b1;
        c.alu_op     = ALU_ADD;
      end
      OP_SW: begin
        c.alu_src   = 1'b1;
        c.mem_write = 1'b1;
        c.alu_op    = ALU_ADD;
      end
      OP_BEQ: begin
        c.branch = 1'b1;
        c.alu_op = ALU_SUB;
      end
      OP_ADDI: begin
        c.alu_src   = 1'b1;
        c.reg_write = 1'b1;
        c.alu_op    = ALU_ADD;
      end
      OP_J:    c.jump = 1'b1;
      default: c.illegal = 1'b1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/id_stage_reg_file_32x32.sv
// 32x32 register file: one write port, two combinational read ports, r0 hardwired to 0.
// Optional ID_WB_BYPASS_EN forwards the in-flight write to matching read ports.
module reg_file_32x32 #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0] ra0,
  input  logic [ADDR_W-1:0] ra1,
  output logic [DATA_W-1:0] rd0,
  output logic [DATA_W-1:0] rd1
);

  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [NREG];
  logic [DATA_W-1:0] stored0, stored1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we && (wa != '0)) begin
      regs[wa] <= wd;
    end
  end

  assign stored0 = (ra0 == '0) ? '0 : regs[ra0];
  assign stored1 = (ra1 == '0) ? '0 : regs[ra1];

`ifdef ID_WB_BYPASS_EN
  assign rd0 = (we && (wa != '0) && (wa == ra0)) ? wd : stored0;
  assign rd1 = (we && (wa != '0) && (wa == ra1)) ? wd : stored1;
`else
  assign rd0 = stored0;
  assign rd1 = stored1;
`endif

endmodule

// File: rtl/id_stage.sv
// Decode stage: IF/ID register with stall/flush, register file and MIPS-subset decoder.
// Build option ID_WB_BYPASS_EN (in reg_file_32x32) enables same-cycle writeback forwarding.
module id_stage
  import id_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] InstructionIn,
  input  logic [DATA_W-1:0] pc_plus4_in,
  input  logic              if_valid,
  input  logic              stall,
  input  logic              flush,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              id_valid,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [4:0]        shamt,
  output logic [5:0]        opcode,
  output logic [5:0]        funct,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [DATA_W-1:0] imm_ext,
  output logic [DATA_W-1:0] branch_target,
  output logic [DATA_W-1:0] jump_target,
  output logic              reg_dst,
  output logic              alu_src,
  output logic              mem_to_reg,
  output logic              reg_write,
  output logic              mem_read,
  output logic              mem_write,
  output logic              branch,
  output logic              jump,
  output logic              illegal,
  output logic [1:0]        alu_op
);

  logic [DATA_W-1:0] ifid_instr;
  logic [DATA_W-1:0] ifid_pc4;
  logic              ifid_valid;
  ctrl_t             ctrl;

  // flush clears instr/valid only; pc_plus4 is irrelevant once valid drops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifid_instr <= '0;
      ifid_pc4   <= '0;
      ifid_valid <= 1'b0;
    end else if (flush) begin
      ifid_instr <= '0;
      ifid_valid <= 1'b0;
    end else if (!stall) begin
      ifid_instr <= InstructionIn;
      ifid_pc4   <= pc_plus4_in;
      ifid_valid <= if_valid;
    end
  end

  assign id_valid = ifid_valid;
  assign opcode   = ifid_instr[31:26];
  assign rs       = ifid_instr[25:21];
  assign rt       = ifid_instr[20:16];
  assign rd       = ifid_instr[15:11];
  assign shamt    = ifid_instr[10:6];
  assign funct    = ifid_instr[5:0];

  assign imm_ext       = {{(DATA_W-16){ifid_instr[15]}}, ifid_instr[15:0]};
  assign branch_target = ifid_pc4 + {imm_ext[DATA_W-3:0], 2'b00};
  assign jump_target   = {ifid_pc4[DATA_W-1:DATA_W-4], ifid_instr[25:0], 2'b00};

  always_comb begin
    ctrl = '0;
    if (ifid_valid) ctrl = decode_op(opcode);
  end

  assign reg_dst    = ctrl.reg_dst;
  assign alu_src    = ctrl.alu_src;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign reg_write  = ctrl.reg_write;
  assign mem_read   = ctrl.mem_read;
  assign mem_write  = ctrl.mem_write;
  assign branch     = ctrl.branch;
  assign jump       = ctrl.jump;
  assign illegal    = ctrl.illegal;
  assign alu_op     = ctrl.alu_op;

  reg_file_32x32 #(
    .DATA_W(DATA_W),
    .ADDR_W(REG_AW)
  ) u_rf (
    .clk (clk),
    .rst (rst),
    .we  (wb_we),
    .wa  (wb_addr),
    .wd  (wb_data),
    .ra0 (rs),
    .ra1 (rt),
    .rd0 (rs_data),
    .rd1 (rt_data)
  );

endmodule

// File: tb/tb_id_stage.sv
// Directed self-checking bench for id_stage; expected values are hand-computed constants.
module tb_id_stage;

  logic        clk;
  logic        rst;
  logic [31:0] InstructionIn;
  logic [31:0] pc_plus4_in;
  logic        if_valid;
  logic        stall;
  logic        flush;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        id_valid;
  logic [4:0]  rs, rt, rd, shamt;
  logic [5:0]  opcode, funct;
  logic [31:0] rs_data, rt_data, imm_ext, branch_target, jump_target;
  logic        reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write;
  logic        branch, jump, illegal;
  logic [1:0]  alu_op;

  int pass_cnt = 0;
  int total_cnt = 0;

  // {reg_dst,alu_src,mem_to_reg,reg_write,mem_read,mem_write,branch,jump,illegal,alu_op}
  logic [10:0] ctrl_vec;
  assign ctrl_vec = {reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write,
                     branch, jump, illegal, alu_op};

  localparam logic [10:0] C_NONE = 11'b00000000000;
  localparam logic [10:0] C_LW   = 11'b01111000000;
  localparam logic [10:0] C_SW   = 11'b01000100000;
  localparam logic [10:0] C_BEQ  = 11'b00000010001;
  localparam logic [10:0] C_ADDI = 11'b01010000000;
  localparam logic [10:0] C_J    = 11'b00000001000;
  localparam logic [10:0] C_R    = 11'b10010000010;
  localparam logic [10:0] C_ILL  = 11'b00000000100;

  id_stage dut (
    .clk(clk), .rst(rst), .InstructionIn(InstructionIn), .pc_plus4_in(pc_plus4_in),
    .if_valid(if_valid), .stall(stall), .flush(flush),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .id_valid(id_valid), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
    .opcode(opcode), .funct(funct), .rs_data(rs_data), .rt_data(rt_data),
    .imm_ext(imm_ext), .branch_target(branch_target), .jump_target(jump_target),
    .reg_dst(reg_dst), .alu_src(alu_src), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .branch(branch), .jump(jump),
    .illegal(illegal), .alu_op(alu_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one rising edge, then leave time for outputs to settle
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] ins, input logic [31:0] pc4, input logic v);
    InstructionIn = ins;
    pc_plus4_in   = pc4;
    if_valid      = v;
    step();
  endtask

  task automatic test_reset();
    InstructionIn = 32'h8C220004;
    pc_plus4_in   = 32'h00000004;
    if_valid      = 1'b1;
    #1 rst = 1'b1;
    step();
    step();
    total_cnt++;
    if (id_valid !== 1'b0) $display("FAIL reset_id_valid got=%b exp=0", id_valid);
    else pass_cnt++;
    total_cnt++;
    if (ctrl_vec !== C_NONE) $display("FAIL reset_ctrl got=%b exp=%b", ctrl_vec, C_NONE);
    else pass_cnt++;
    total_cnt++;
    if (rs_data !== 32'h0) $display("FAIL reset_rs_data got=%h exp=0", rs_data);
    else pass_cnt++;
    rst = 1'b0;
    step();
    total_cnt++;
    if (ctrl_vec !== C_LW || id_valid !== 1'b1)
      $display("FAIL lw_ctrl got=%b/%b exp=%b/1", ctrl_vec, id_valid, C_LW);
    else pass_cnt++;
    total_cnt++;
    if (rs !== 5'd1 || rt !== 5'd2) $display("FAIL lw_fields got rs=%0d rt=%0d exp rs=1 rt=2", rs, rt);
    else pass_cnt++;
    total_cnt++;
    if (imm_ext !== 32'h4) $display("FAIL lw_imm got=%h exp=00000004", imm_ext);
    else pass_cnt++;
    total_cnt++;
    if (opcode !== 6'h23) $display("FAIL lw_opcode got=%h exp=23", opcode);
    else pass_cnt++;
  endtask

  task automatic test_branch_jump();
    load(32'h1000FFFF, 32'h00000010, 1'b1);
    total_cnt++;
    if (ctrl_vec !== C_BEQ) $display("FAIL beq_ctrl got=%b exp=%b", ctrl_vec, C_BEQ);
    else pass_cnt++;
    total_cnt++;
    if (imm_ext !== 32'hFFFFFFFF) $display("FAIL beq_imm got=%h exp=ffffffff", imm_ext);
    else pass_cnt++;
    total_cnt++;
    if (branch_target !== 32'h0000000C) $display("FAIL beq_target got=%h exp=0000000c", branch_target);
    else pass_cnt++;
    load(32'h10007FFF, 32'hFFFFFFF0, 1'b1);
    total_cnt++;
    if (branch_target !== 32'h0001FFEC) $display("FAIL beq_wrap got=%h exp=0001ffec", branch_target);
    else pass_cnt++;
    load(32'h08000400, 32'h40000004, 1'b1);
    total_cnt++;
    if (ctrl_vec !== C_J) $display("FAIL j_ctrl got=%b exp=%b", ctrl_vec, C_J);
    else pass_cnt++;
    total_cnt++;
    if (jump_target !== 32'h40001000) $display("FAIL j_target got=%h exp=40001000", jump_target);
    else pass_cnt++;
    load(32'hAC220008, 32'h00000020, 1'b1);
    total_cnt++;
    if (ctrl_vec !== C_SW) $display("FAIL sw_ctrl got=%b exp=%b", ctrl_vec, C_SW);
    else pass_cnt++;
    load(32'h2001FFFF, 32'h00000024, 1'b1);
    total_cnt++;
    if (ctrl_vec !== C_ADDI || imm_ext !== 32'hFFFFFFFF)
      $display("FAIL addi got ctrl=%b imm=%h exp ctrl=%b imm=ffffffff", ctrl_vec, imm_ext, C_ADDI);
    else pass_cnt++;
  endtask

  task automatic test_rtype_wb();
    wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
    InstructionIn = 32'h00A53020; pc_plus4_in = 32'h00000030; if_valid = 1'b1;
    step();
    wb_we = 1'b0;
    #1;
    total_cnt++;
    if (rs_data !== 32'hDEADBEEF || rt_data !== 32'hDEADBEEF)
      $display("FAIL add_data got rs=%h rt=%h exp deadbeef", rs_data, rt_data);
    else pass_cnt++;
    total_cnt++;
    if (ctrl_vec !== C_R) $display("FAIL add_ctrl got=%b exp=%b", ctrl_vec, C_R);
    else pass_cnt++;
    total_cnt++;
    if (rd !== 5'd6 || funct !== 6'h20 || shamt !== 5'd0)
      $display("FAIL add_fields got rd=%0d funct=%h shamt=%0d exp 6/20/0", rd, funct, shamt);
    else pass_cnt++;
    wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFFFFFF;
    InstructionIn = 32'h00000020;
    step();
    wb_we = 1'b0;
    #1;
    total_cnt++;
    if (rs_data !== 32'h0 || rt_data !== 32'h0)
      $display("FAIL r0_write got rs=%h rt=%h exp 0", rs_data, rt_data);
    else pass_cnt++;
  endtask

  task automatic test_stall_flush();
    load(32'h8C220004, 32'h00000100, 1'b1);
    stall = 1'b1;
    wb_we = 1'b1; wb_addr = 5'd1; wb_data = 32'hCAFE0001;
    for (int i = 0; i < 3; i++) begin
      InstructionIn = 32'hAC000000 + 32'(i);
      if_valid = i[0];
      step();
      wb_we = 1'b0;
      #1;
      total_cnt++;
      if (ctrl_vec !== C_LW || id_valid !== 1'b1 || imm_ext !== 32'h4 || rs !== 5'd1)
        $display("FAIL stall_hold_%0d got ctrl=%b v=%b imm=%h rs=%0d", i, ctrl_vec, id_valid, imm_ext, rs);
      else pass_cnt++;
    end
    total_cnt++;
    if (rs_data !== 32'hCAFE0001) $display("FAIL stall_wb got=%h exp=cafe0001", rs_data);
    else pass_cnt++;
    flush = 1'b1;
    InstructionIn = 32'h8C220004; if_valid = 1'b1;
    step();
    total_cnt++;
    if (id_valid !== 1'b0 || ctrl_vec !== C_NONE)
      $display("FAIL stall_flush got v=%b ctrl=%b exp 0", id_valid, ctrl_vec);
    else pass_cnt++;
    total_cnt++;
    if (opcode !== 6'h00 || imm_ext !== 32'h0)
      $display("FAIL flush_bubble got op=%h imm=%h exp 0", opcode, imm_ext);
    else pass_cnt++;
    flush = 1'b0; stall = 1'b0;
  endtask

  task automatic test_illegal();
    load(32'hFC000000, 32'h00000200, 1'b1);
    total_cnt++;
    if (ctrl_vec !== C_ILL) $display("FAIL illegal_valid got=%b exp=%b", ctrl_vec, C_ILL);
    else pass_cnt++;
    load(32'hFC000000, 32'h00000200, 1'b0);
    total_cnt++;
    if (ctrl_vec !== C_NONE || id_valid !== 1'b0)
      $display("FAIL illegal_invalid got ctrl=%b v=%b exp 0", ctrl_vec, id_valid);
    else pass_cnt++;
    total_cnt++;
    if (opcode !== 6'h3F) $display("FAIL invalid_fields got op=%h exp=3f", opcode);
    else pass_cnt++;
  endtask

  task automatic test_same_cycle();
    wb_we = 1'b1; wb_addr = 5'd7; wb_data = 32'h11111111;
    step();
    wb_we = 1'b0;
    load(32'h20E80001, 32'h00000300, 1'b1);
    wb_we = 1'b1; wb_addr = 5'd7; wb_data = 32'h12345678;
    #1;
    total_cnt++;
`ifdef ID_WB_BYPASS_EN
    if (rs_data !== 32'h12345678) $display("FAIL same_cycle_bypass got=%h exp=12345678", rs_data);
    else pass_cnt++;
`else
    if (rs_data !== 32'h11111111) $display("FAIL same_cycle_old got=%h exp=11111111", rs_data);
    else pass_cnt++;
`endif
    total_cnt++;
    if (rt_data !== 32'h0) $display("FAIL same_cycle_rt got=%h exp=0", rt_data);
    else pass_cnt++;
    stall = 1'b1;
    step();
    wb_we = 1'b0;
    #1;
    total_cnt++;
    if (rs_data !== 32'h12345678) $display("FAIL after_write got=%h exp=12345678", rs_data);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_stall();
    stall = 1'b0;
    load(32'h8C220004, 32'h00000400, 1'b1);
    stall = 1'b1;
    step();
    #2 rst = 1'b1;
    #1;
    total_cnt++;
    if (id_valid !== 1'b0 || ctrl_vec !== C_NONE || rs !== 5'd0)
      $display("FAIL mid_stall_rst got v=%b ctrl=%b rs=%0d exp 0", id_valid, ctrl_vec, rs);
    else pass_cnt++;
    rst = 1'b0;
    stall = 1'b0;
    load(32'h00E53820, 32'h00000404, 1'b1);
    total_cnt++;
    if (rs_data !== 32'h0 || rt_data !== 32'h0)
      $display("FAIL rf_cleared got rs=%h rt=%h exp 0", rs_data, rt_data);
    else pass_cnt++;
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
    wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    InstructionIn = '0; pc_plus4_in = '0; if_valid = 1'b0;
    test_reset();
    test_branch_jump();
    test_rtype_wb();
    test_stall_flush();
    test_illegal();
    test_same_cycle();
    test_reset_mid_stall();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
